// File: rtl/spi_adc_target_pkg.sv
// Shared constants, instruction width-field encoding and FSM states for the
// SPI ADC register-map target.
`timescale 1ns/1ps
package spi_adc_pkg;

    localparam int INSTR_BITS = 16;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        W_1BYTE  = 2'b00,
        W_2BYTE  = 2'b01,
        W_3BYTE  = 2'b10,
        W_STREAM = 2'b11
    } width_t;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WDATA,
        RDATA,
        DONE
    } state_t;

    // The W field encodes (byte count - 1), so the last byte is the one whose index equals W.
    function automatic logic is_last_byte(input width_t w, input logic [1:0] cnt);
        return (w != W_STREAM) && (cnt == 2'(w));
    endfunction

endpackage

// File: rtl/spi_adc_target_if.sv
// Register strobe bus between the SPI target (master side) and the fabric
// register map (slave side).
`timescale 1ns/1ps
interface spi_adc_target_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_strobe;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_strobe, wr_addr, wr_data, rd_strobe, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_strobe, wr_addr, wr_data, rd_strobe, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/spi_adc_target_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin, plus one history flop for
// single-cycle rise/fall pulses on the synchronized level.
`timescale 1ns/1ps
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Clearing to 0 means a pin already low at reset release never yields a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_adc_target.sv
// 3-wire SPI target decoding ADC-style register frames (16-bit instruction,
// then data bytes) into a simple register strobe bus, oversampled on sys_clk.
`timescale 1ns/1ps
module spi_adc_target #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    csb,
    input  logic                    sdio_i,
    output logic                    sdio_o,
    output logic                    sdio_oe,
    output logic                    busy,
    output logic                    frame_error,
    spi_adc_target_if.master        bus
);
    import spi_adc_pkg::*;

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_csb_level, w_csb_rise, w_csb_fall;
    logic w_sdio, w_sdio_rise, w_sdio_fall;
    logic w_unused_sdio_edges;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(sys_clk), .reset(reset), .i_async(sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csb (
        .clk(sys_clk), .reset(reset), .i_async(csb),
        .o_level(w_csb_level), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdio (
        .clk(sys_clk), .reset(reset), .i_async(sdio_i),
        .o_level(w_sdio), .o_rise(w_sdio_rise), .o_fall(w_sdio_fall)
    );

    assign w_unused_sdio_edges = &{1'b0, w_sdio_rise, w_sdio_fall, w_sclk_level};

    state_t                  r_state;
    width_t                  r_w;
    logic [3:0]              r_bit_cnt;
    logic [1:0]              r_byte_cnt;
    logic [INSTR_BITS-1:0]   r_shift;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_tx;
    logic                    r_cap;
    logic                    r_tx_ready;
    logic                    r_armed;
    logic                    r_sdio_o;
    logic                    r_sdio_oe;
    logic                    r_frame_error;
    logic                    r_wr_strobe;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;
    logic                    r_rd_strobe;
    logic [ADDR_W-1:0]       r_rd_addr;

    logic [INSTR_BITS-1:0]   w_instr;
    logic [ADDR_W-1:0]       w_addr_dec;
    logic                    w_last;

    assign w_instr    = {r_shift[INSTR_BITS-2:0], w_sdio};
    assign w_addr_dec = r_addr - ADDR_W'(1);
    assign w_last     = is_last_byte(r_w, r_byte_cnt);

    // A csb rise is handled before any sclk edge in the same cycle, so that edge is dropped.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_w           <= W_1BYTE;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_shift       <= '0;
            r_addr        <= '0;
            r_tx          <= '0;
            r_cap         <= 1'b0;
            r_tx_ready    <= 1'b0;
            r_armed       <= 1'b0;
            r_sdio_o      <= 1'b0;
            r_sdio_oe     <= 1'b0;
            r_frame_error <= 1'b0;
            r_wr_strobe   <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_rd_strobe   <= 1'b0;
            r_rd_addr     <= '0;
        end else begin
            r_wr_strobe   <= 1'b0;
            r_rd_strobe   <= 1'b0;
            r_frame_error <= 1'b0;
            r_cap         <= r_rd_strobe;
            if (w_csb_level) begin
                r_armed <= 1'b1;
            end
            // Fabric data is valid the cycle after rd_strobe, so it is captured one cycle later.
            if (r_cap) begin
                r_tx       <= bus.rd_data;
                r_tx_ready <= 1'b1;
            end

            if (w_csb_rise) begin
                r_state    <= IDLE;
                r_sdio_oe  <= 1'b0;
                r_sdio_o   <= 1'b0;
                r_tx_ready <= 1'b0;
                if (r_state == INSTR ||
                    ((r_state == WDATA || r_state == RDATA) && r_bit_cnt != 4'd0)) begin
                    r_frame_error <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_csb_fall) begin
                            r_state    <= INSTR;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                            r_tx_ready <= 1'b0;
                        end
                    end
                    INSTR: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_instr;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'(INSTR_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                r_w       <= width_t'(w_instr[ADDR_W+1:ADDR_W]);
                                r_addr    <= w_instr[ADDR_W-1:0];
                                if (w_instr[INSTR_BITS-1]) begin
                                    r_rd_strobe <= 1'b1;
                                    r_rd_addr   <= w_instr[ADDR_W-1:0];
                                    r_state     <= RDATA;
                                end else begin
                                    r_state <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_instr;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'(DATA_W - 1)) begin
                                r_bit_cnt   <= '0;
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_addr;
                                r_wr_data   <= w_instr[DATA_W-1:0];
                                r_addr      <= w_addr_dec;
                                r_byte_cnt  <= r_byte_cnt + 2'd1;
                                if (w_last) begin
                                    r_state <= DONE;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (w_sclk_fall) begin
                            if (r_tx_ready) begin
                                r_sdio_oe  <= 1'b1;
                                r_sdio_o   <= r_tx[DATA_W-1];
                                r_tx       <= {r_tx[DATA_W-2:0], 1'b0};
                                r_tx_ready <= 1'b0;
                            end else if (r_sdio_oe) begin
                                r_sdio_o <= r_tx[DATA_W-1];
                                r_tx     <= {r_tx[DATA_W-2:0], 1'b0};
                            end
                        end
                        if (w_sclk_rise && r_sdio_oe) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'(DATA_W - 1)) begin
                                r_bit_cnt  <= '0;
                                r_addr     <= w_addr_dec;
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                                if (w_last) begin
                                    r_sdio_oe <= 1'b0;
                                    r_state   <= DONE;
                                end else begin
                                    r_rd_strobe <= 1'b1;
                                    r_rd_addr   <= w_addr_dec;
                                end
                            end
                        end
                    end
                    DONE: begin
                        r_sdio_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sdio_o        = r_sdio_o;
    assign sdio_oe       = r_sdio_oe;
    assign frame_error   = r_frame_error;
    assign busy          = r_armed & ~w_csb_level;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.rd_strobe = r_rd_strobe;
    assign bus.rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_spi_adc_target.sv
// Directed bench for spi_adc_target: plays an SPI master on the pads and a
// register-map responder on the strobe bus.
`timescale 1ns/1ps
module tb_spi_adc_target;

    logic sys_clk = 1'b0;
    logic reset, sclk, csb, sdio_i;
    logic sdio_o, sdio_oe, busy, frame_error;

    int checks = 0;
    int errors = 0;

    logic [12:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [12:0] rd_addr_q[$];
    int          fe_cnt;
    time         last_rise_t;
    time         wr_t;
    time         rd_t;

    spi_adc_target_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    spi_adc_target #(.SYNC_STAGES(2), .ADDR_W(13), .DATA_W(8)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sclk        (sclk),
        .csb         (csb),
        .sdio_i      (sdio_i),
        .sdio_o      (sdio_o),
        .sdio_oe     (sdio_oe),
        .busy        (busy),
        .frame_error (frame_error),
        .bus         (bus)
    );

    always #10 sys_clk = ~sys_clk;

    function automatic logic [7:0] fabric_value(input logic [12:0] a);
        return (a == 13'h0014) ? 8'h5C : (a[7:0] ^ 8'h3C);
    endfunction

    // Register-map responder and event log, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (bus.wr_strobe) begin
            wr_addr_q.push_back(bus.wr_addr);
            wr_data_q.push_back(bus.wr_data);
            wr_t = $time;
        end
        if (bus.rd_strobe) begin
            rd_addr_q.push_back(bus.rd_addr);
            bus.rd_data = fabric_value(bus.rd_addr);
            rd_t = $time;
        end
        if (frame_error) fe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        fe_cnt = 0;
    endtask

    task automatic csb_low();
        @(negedge sys_clk);
        csb = 1'b0;
        wait_cycles(6);
    endtask

    task automatic csb_high();
        @(negedge sys_clk);
        csb = 1'b1;
        wait_cycles(6);
    endtask

    task automatic send_bit(input logic b);
        @(negedge sys_clk);
        sdio_i = b;
        wait_cycles(5);
        sclk = 1'b1;
        last_rise_t = $time;
        wait_cycles(5);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[15-i]);
    endtask

    task automatic read_bits(input int n, output logic [7:0] d, output int oe_hits);
        d = '0;
        oe_hits = 0;
        for (int i = 0; i < n; i++) begin
            wait_cycles(5);
            sclk = 1'b1;
            d = {d[6:0], sdio_o};
            if (sdio_oe) oe_hits++;
            wait_cycles(5);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; csb = 1'b1; sclk = 1'b0; sdio_i = 1'b0; bus.rd_data = '0;
        fe_cnt = 0;
        wait_cycles(4);
        checks++;
        if ({sdio_o, sdio_oe, busy, frame_error, bus.wr_strobe, bus.rd_strobe} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000",
                     {sdio_o, sdio_oe, busy, frame_error, bus.wr_strobe, bus.rd_strobe});
        end
        checks++;
        if ({bus.wr_addr, bus.wr_data, bus.rd_addr} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_buses: got %h expected 0", {bus.wr_addr, bus.wr_data, bus.rd_addr});
        end
        reset = 1'b0;
        wait_cycles(6);
    endtask

    task automatic test_write_single();
        clear_log();
        csb_low();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_low: got %b expected 1", busy); end
        send_bits(16'h0014, 16);
        send_bits({8'hA5, 8'h00}, 8);
        checks++;
        if (wr_t - last_rise_t !== 60) begin
            errors++;
            $display("[TB] FAIL wr_latency: got %0t expected 60", wr_t - last_rise_t);
        end
        checks++;
        if (sdio_oe !== 1'b0) begin errors++; $display("[TB] FAIL wr_oe: got %b expected 0", sdio_oe); end
        csb_high();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_high: got %b expected 0", busy); end
        checks++;
        if (wr_addr_q.size() != 1) begin
            errors++; $display("[TB] FAIL wr1_count: got %0d expected 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 13'h0014 || wr_data_q[0] !== 8'hA5) begin
            errors++; $display("[TB] FAIL wr1_value: got %h/%h expected 0014/a5", wr_addr_q[0], wr_data_q[0]);
        end
        checks++;
        if (fe_cnt != 0) begin errors++; $display("[TB] FAIL wr1_ferr: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_read_single();
        logic [7:0] d;
        int oe_hits;
        clear_log();
        csb_low();
        send_bits(16'h8014, 16);
        checks++;
        if (rd_t - last_rise_t !== 60) begin
            errors++; $display("[TB] FAIL rd_latency: got %0t expected 60", rd_t - last_rise_t);
        end
        read_bits(8, d, oe_hits);
        checks++;
        if (d !== 8'h5C) begin errors++; $display("[TB] FAIL rd1_data: got %h expected 5c", d); end
        checks++;
        if (oe_hits != 8) begin errors++; $display("[TB] FAIL rd1_oe_bits: got %0d expected 8", oe_hits); end
        wait_cycles(6);
        checks++;
        if (sdio_oe !== 1'b0) begin errors++; $display("[TB] FAIL rd1_oe_after: got %b expected 0", sdio_oe); end
        csb_high();
        checks++;
        if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 13'h0014) begin
            errors++; $display("[TB] FAIL rd1_addr: got n=%0d expected one strobe at 0014", rd_addr_q.size());
        end
        checks++;
        if (fe_cnt != 0) begin errors++; $display("[TB] FAIL rd1_ferr: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_multi_write();
        clear_log();
        csb_low();
        send_bits(16'h2020, 16);
        send_bits({8'h11, 8'h00}, 8);
        send_bits({8'h22, 8'h00}, 8);
        send_bits({8'h33, 8'h00}, 8);
        csb_high();
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++; $display("[TB] FAIL wr2_count: got %0d expected 2", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 13'h0020 || wr_data_q[0] !== 8'h11 ||
                     wr_addr_q[1] !== 13'h001F || wr_data_q[1] !== 8'h22) begin
            errors++;
            $display("[TB] FAIL wr2_values: got %h/%h %h/%h expected 0020/11 001f/22",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
        end
        checks++;
        if (fe_cnt != 0) begin errors++; $display("[TB] FAIL wr2_ferr: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_stream_wrap();
        logic [7:0] d0, d1, d2;
        int oe_hits;
        clear_log();
        csb_low();
        send_bits(16'hE000, 16);
        read_bits(8, d0, oe_hits);
        read_bits(8, d1, oe_hits);
        read_bits(8, d2, oe_hits);
        checks++;
        if ({d0, d1, d2} !== 24'h3CC3C2) begin
            errors++; $display("[TB] FAIL stream_data: got %h expected 3cc3c2", {d0, d1, d2});
        end
        csb_high();
        checks++;
        if (rd_addr_q.size() != 4) begin
            errors++; $display("[TB] FAIL stream_count: got %0d expected 4", rd_addr_q.size());
        end else if (rd_addr_q[0] !== 13'h0000 || rd_addr_q[1] !== 13'h1FFF ||
                     rd_addr_q[2] !== 13'h1FFE || rd_addr_q[3] !== 13'h1FFD) begin
            errors++;
            $display("[TB] FAIL stream_addr: got %h %h %h %h expected 0000 1fff 1ffe 1ffd",
                     rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]);
        end
        checks++;
        if (sdio_oe !== 1'b0) begin errors++; $display("[TB] FAIL stream_oe: got %b expected 0", sdio_oe); end
        checks++;
        if (fe_cnt != 0) begin errors++; $display("[TB] FAIL stream_ferr: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_abort();
        clear_log();
        csb_low();
        send_bits(16'h0014, 10);
        csb_high();
        checks++;
        if (fe_cnt != 1) begin errors++; $display("[TB] FAIL abort_instr: got %0d expected 1", fe_cnt); end
        csb_low();
        send_bits(16'h0030, 16);
        send_bits({8'hF0, 8'h00}, 4);
        csb_high();
        checks++;
        if (fe_cnt != 2) begin errors++; $display("[TB] FAIL abort_data: got %0d expected 2", fe_cnt); end
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++; $display("[TB] FAIL abort_no_wr: got %0d expected 0", wr_addr_q.size());
        end
        csb_low();
        send_bits(16'h0031, 16);
        send_bits({8'h3C, 8'h00}, 8);
        csb_high();
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 13'h0031 || wr_data_q[0] !== 8'h3C || fe_cnt != 2) begin
            errors++;
            $display("[TB] FAIL abort_recover: got n=%0d fe=%0d expected one write 0031/3c fe=2",
                     wr_addr_q.size(), fe_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        int oe_hits;
        clear_log();
        csb_low();
        send_bits(16'h8014, 16);
        read_bits(3, d, oe_hits);
        checks++;
        if (sdio_oe !== 1'b1) begin errors++; $display("[TB] FAIL midread_oe: got %b expected 1", sdio_oe); end
        @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({sdio_o, sdio_oe, busy, frame_error, bus.wr_strobe, bus.rd_strobe} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %b expected 000000",
                     {sdio_o, sdio_oe, busy, frame_error, bus.wr_strobe, bus.rd_strobe});
        end
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(4);
        clear_log();
        send_bits(16'h0040, 16);
        send_bits({8'h99, 8'h00}, 8);
        checks++;
        if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0 || sdio_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL postreset_quiet: got wr=%0d rd=%0d oe=%b expected 0 0 0",
                     wr_addr_q.size(), rd_addr_q.size(), sdio_oe);
        end
        csb_high();
        csb_low();
        send_bits(16'h0041, 16);
        send_bits({8'h77, 8'h00}, 8);
        csb_high();
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 13'h0041 || wr_data_q[0] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL postreset_frame: got n=%0d expected one write 0041/77", wr_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_single();
        test_multi_write();
        test_stream_wrap();
        test_abort();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
